// File: rtl/rat_port_responder.sv
// rat_port_responder: peripheral end of the RAT MCU port bus.
// Holds the LED and seven-segment output registers, a combinational read mux,
// a prescaled down-count interval timer, synchronized button edge detection
// and a two-source interrupt controller (timer = bit 0, buttons = bit 1).
module rat_port_responder #(
   parameter logic [7:0] LEDS_ID     = 8'h40,
   parameter logic [7:0] SSEG_ID     = 8'h81,
   parameter logic [7:0] TMR_ID      = 8'hB0,
   parameter logic [7:0] MASK_ID     = 8'hB1,
   parameter logic [7:0] ACK_ID      = 8'hB2,
   parameter logic [7:0] SWITCHES_ID = 8'h20,
   parameter logic [7:0] BUTTONS_ID  = 8'h24,
   parameter int         PRESCALE    = 1000
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] PORT_ID,
   input  logic [7:0] OUT_PORT,
   input  logic       IO_STRB,
   output logic [7:0] IN_PORT,
   output logic       INT_CU,
   input  logic [7:0] SWITCHES,
   input  logic [3:0] BUTTONS,
   output logic [7:0] LEDS,
   output logic [7:0] SSEG_VAL
);

   // Prescaler width; PRESCALE is at least 2 so this is never zero.
   localparam int PSC_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);
   localparam logic [PSC_W-1:0] PSC_ONE  = PSC_W'(1);

   // Architectural state
   logic [7:0]       leds_q,   leds_d;
   logic [7:0]       sseg_q,   sseg_d;
   logic [7:0]       reload_q, reload_d;
   logic [7:0]       count_q,  count_d;
   logic [PSC_W-1:0] psc_q,    psc_d;
   logic [1:0]       mask_q,   mask_d;
   logic [1:0]       pend_q,   pend_d;
   logic             int_q,    int_d;

   // Button synchronizer (two flops) followed by the edge reference flop
   logic [3:0] btn_meta_q;
   logic [3:0] btn_sync_q;
   logic [3:0] btn_prev_q;

   // Write decode and event signals
   logic       wr_leds;
   logic       wr_sseg;
   logic       wr_tmr;
   logic       wr_mask;
   logic       wr_ack;
   logic       timer_run;
   logic       tick;
   logic       tmr_expire;
   logic [3:0] btn_rise;
   logic [1:0] pend_set;
   logic [1:0] ack_clr;

   // Decode which register, if any, the current strobe targets
   always_comb begin
      wr_leds = IO_STRB && (PORT_ID == LEDS_ID);
      wr_sseg = IO_STRB && (PORT_ID == SSEG_ID);
      wr_tmr  = IO_STRB && (PORT_ID == TMR_ID);
      wr_mask = IO_STRB && (PORT_ID == MASK_ID);
      wr_ack  = IO_STRB && (PORT_ID == ACK_ID);
   end

   // Timer next state: a TMR write reloads everything and beats a same-cycle tick
   always_comb begin
      timer_run  = (reload_q != 8'h00);
      tick       = timer_run && (psc_q == PSC_LAST);
      tmr_expire = 1'b0;
      reload_d   = reload_q;
      count_d    = count_q;
      psc_d      = psc_q;
      if (wr_tmr) begin
         reload_d = OUT_PORT;
         count_d  = OUT_PORT;
         psc_d    = '0;
      end else if (timer_run) begin
         if (tick) begin
            psc_d = '0;
            if (count_q == 8'd1) begin
               tmr_expire = 1'b1;
               count_d    = reload_q;
            end else begin
               count_d = count_q - 8'd1;
            end
         end else begin
            psc_d = psc_q + PSC_ONE;
         end
      end
   end

   // Interrupt next state: set events win over a same-cycle acknowledge
   always_comb begin
      btn_rise = btn_sync_q & ~btn_prev_q;
      pend_set = {|btn_rise, tmr_expire};
      ack_clr  = wr_ack ? OUT_PORT[1:0] : 2'b00;
      pend_d   = (pend_q & ~ack_clr) | pend_set;
      mask_d   = wr_mask ? OUT_PORT[1:0] : mask_q;
      int_d    = |(pend_q & mask_q);
   end

   // Output register next state
   always_comb begin
      leds_d = wr_leds ? OUT_PORT : leds_q;
      sseg_d = wr_sseg ? OUT_PORT : sseg_q;
   end

   // All state registers; reset overrides any same-cycle write or event
   always_ff @(posedge CLK) begin
      if (RESET) begin
         leds_q     <= 8'h00;
         sseg_q     <= 8'h00;
         reload_q   <= 8'h00;
         count_q    <= 8'h00;
         psc_q      <= '0;
         mask_q     <= 2'b00;
         pend_q     <= 2'b00;
         int_q      <= 1'b0;
         btn_meta_q <= 4'h0;
         btn_sync_q <= 4'h0;
         btn_prev_q <= 4'h0;
      end else begin
         leds_q     <= leds_d;
         sseg_q     <= sseg_d;
         reload_q   <= reload_d;
         count_q    <= count_d;
         psc_q      <= psc_d;
         mask_q     <= mask_d;
         pend_q     <= pend_d;
         int_q      <= int_d;
         btn_meta_q <= BUTTONS;
         btn_sync_q <= btn_meta_q;
         btn_prev_q <= btn_sync_q;
      end
   end

   // Zero-latency read mux driven purely by PORT_ID
   always_comb begin
      IN_PORT = 8'h00;
      case (PORT_ID)
         SWITCHES_ID: IN_PORT = SWITCHES;
         BUTTONS_ID:  IN_PORT = {4'h0, btn_sync_q};
         TMR_ID:      IN_PORT = count_q;
         MASK_ID:     IN_PORT = {6'h00, mask_q};
         ACK_ID:      IN_PORT = {6'h00, pend_q};
         default:     IN_PORT = 8'h00;
      endcase
   end

   assign LEDS     = leds_q;
   assign SSEG_VAL = sseg_q;
   assign INT_CU   = int_q;

endmodule

// File: doc/rat_port_responder.md
Name: rat_port_responder

Overview:
Peripheral-side responder for the RAT MCU port bus. It sits at the far end of the MCU's PORT_ID / OUT_PORT / IO_STRB / IN_PORT / INT_CU interface and contains the following:
- Output registers for LEDs and seven-segment value.
- A combinational input-port read mux for switches, buttons, status and timer.
- A programmable down-count interval timer.
- Button edge detection.
- An interrupt request/acknowledge controller that drives the MCU interrupt line.

Parameters:
LEDS_ID, 8'h40, port address of LED output register (W)
SSEG_ID, 8'h81, port address of seven-seg value register (W)
TMR_ID, 8'hB0, timer reload register (W); current count (R)
MASK_ID, 8'hB1, interrupt mask register (W/R, bits [1:0] used)
ACK_ID, 8'hB2, interrupt acknowledge (W, write-1-to-clear); pending status (R)
SWITCHES_ID, 8'h20, switch input port (R)
BUTTONS_ID, 8'h24, synchronized button input port (R, bits [3:0])
PRESCALE, 1000, CLK cycles per timer tick (must be >= 2)

Ports:
CLK  in  1  system clock, all state on rising edge
RESET  in  1  synchronous, active-high reset
PORT_ID  in  8  port address from MCU
OUT_PORT  in  8  write data from MCU
IO_STRB  in  1  one-cycle write strobe from MCU
IN_PORT  out  8  read data to MCU (combinational from PORT_ID)
INT_CU  out  1  interrupt request to MCU control unit
SWITCHES  in  8  board switches (assumed static, not synchronized)
BUTTONS  in  4  raw board buttons (asynchronous)
LEDS  out  8  LED register
SSEG_VAL  out  8  seven-seg value register

Behaviour:
- Reset (RESET=1 at a rising edge) clears the following to 0: LEDS, SSEG_VAL, reload, count, prescaler, mask, pending, and the button synchronizer and edge registers. INT_CU is 0 during the first cycle after reset.
- Writes:
  - Take effect at the rising edge where IO_STRB=1; the new value is visible the next cycle.
  - Only the register decoded from PORT_ID is affected. Unmapped IDs are ignored.
  - IO_STRB=0 means no write regardless of PORT_ID.
- Reads: IN_PORT is purely combinational on PORT_ID, with zero latency.
  - SWITCHES_ID -> SWITCHES
  - BUTTONS_ID -> {4'h0, btn_sync}
  - TMR_ID -> count
  - MASK_ID -> {6'h0, mask}
  - ACK_ID -> {6'h0, pending}
  - any other ID -> 8'h00
- Buttons:
  - Two-flop synchronizer per bit, then a one-flop edge register.
  - A rising edge on any synchronized bit sets pending[1].
  - Latency from BUTTONS change to pending[1]=1 is 3 rising edges.
- Timer:
  - A prescaler counts 0..PRESCALE-1 and wraps; a tick is generated on the wrap cycle.
  - The prescaler runs only when reload != 0.
  - On a tick: if count == 1, set pending[0] and set count <= reload; otherwise count <= count - 1.
  - Writing TMR_ID loads reload and count with OUT_PORT and clears the prescaler. The write has priority over a same-cycle tick.
  - reload == 0 disables the timer: count holds at 0 and no ticks occur.
- Interrupt:
  - INT_CU = |(pending & mask), registered (one cycle after a pending or mask update).
  - A pending bit stays set until acknowledged. Masked pending bits are retained.
  - Acknowledge: a write to ACK_ID clears each pending bit where OUT_PORT has a 1.
  - If a set event and an ack of the same bit occur in the same cycle, set wins and the bit stays 1.
- Reset mid-operation: RESET overrides any same-cycle write, tick or edge event.

Test Plan:
1. Reset: assert RESET for 2 cycles with IO_STRB=1, PORT_ID=8'h40, OUT_PORT=8'hFF -> LEDS=0, SSEG_VAL=0, INT_CU=0, and IN_PORT at 8'hB2 reads 8'h00.
2. Output/readback: strobe 8'hA5 to 8'h40 and 8'h3C to 8'h81; drive SWITCHES=8'h5A, PORT_ID=8'h20 -> LEDS=8'hA5 and SSEG_VAL=8'h3C the next cycle; IN_PORT=8'h5A combinationally. PORT_ID=8'h99 -> IN_PORT=8'h00. A write to 8'h99 changes nothing.
3. Timer (PRESCALE=4): write mask 8'h01, then reload 8'h03 -> count reads 3, 2, 1 at 4-cycle spacing. pending[0] sets on the 12th cycle after the write, count reloads to 3, and INT_CU=1 one cycle later. Write 8'h01 to 8'hB2 -> INT_CU=0 the next cycle, and the timer keeps running.
4. Button interrupt: mask=8'h02; raise BUTTONS[2] -> pending=2'b10 after 3 edges, then INT_CU=1. Hold the button high -> no retrigger after the ack. Release and re-press -> it sets again.
5. Collision: time an ACK_ID write of 8'h01 to coincide with a timer expiry -> pending[0] stays 1 and INT_CU stays 1. Write reload=0 -> count=0, and no further pending[0].
6. Masking: with mask=0, a button press -> pending=2'b10 and INT_CU=0. Then write mask=8'h02 -> INT_CU=1 one cycle later.
